// File: rtl/pcie_tlp_egress_pkg.sv
// Shared definitions for the memory-request TLP egress engine: header field
// encodings, field positions and controller states.
package pcie_tlp_egress_pkg;

    localparam logic [2:0] FMT_MRD_3DW = 3'b000;
    localparam logic [2:0] FMT_MRD_4DW = 3'b001;
    localparam logic [2:0] FMT_MWR_3DW = 3'b010;
    localparam logic [2:0] FMT_MWR_4DW = 3'b011;
    localparam logic [4:0] TYPE_MEM    = 5'b00000;
    localparam logic [3:0] FIRST_BE    = 4'hF;

    localparam int unsigned HDR_FMT_LSB    = 29;
    localparam int unsigned HDR_TYPE_LSB   = 24;
    localparam int unsigned HDR_FLAGS_LSB  = 10;
    localparam int unsigned HDR_LENGTH_LSB = 0;

    typedef enum logic [2:0] {
        StIdle,
        StWaitForFifo,
        StCalc,
        StSendHdr,
        StSendData,
        StNext,
        StFinished
    } state_e;

    function automatic logic [2:0] hdr_fmt(input logic write, input logic addr64);
        logic [2:0] fmt;
        unique case ({write, addr64})
            2'b00:   fmt = FMT_MRD_3DW;
            2'b01:   fmt = FMT_MRD_4DW;
            2'b10:   fmt = FMT_MWR_3DW;
            default: fmt = FMT_MWR_4DW;
        endcase
        return fmt;
    endfunction

endpackage

// File: rtl/pcie_tlp_hdr_gen.sv
// Combinational TLP header dword mux; idx selects dword0..dword3 of a
// 3DW or 4DW memory request header.
module pcie_tlp_hdr_gen
    import pcie_tlp_egress_pkg::*;
(
    input  logic        write,
    input  logic        addr64,
    input  logic [61:0] addr,
    input  logic [9:0]  length,
    input  logic        single,
    input  logic [13:0] flags,
    input  logic [15:0] requester_id,
    input  logic [7:0]  tag,
    input  logic [1:0]  idx,
    output logic [31:0] dword
);

    logic [31:0] dw0;
    logic [31:0] dw1;
    logic [31:0] addr_lo;

    always_comb begin
        dw0 = '0;
        dw0[HDR_FMT_LSB +: 3]     = hdr_fmt(write, addr64);
        dw0[HDR_TYPE_LSB +: 5]    = TYPE_MEM;
        dw0[HDR_FLAGS_LSB +: 14]  = flags;
        dw0[HDR_LENGTH_LSB +: 10] = length;
        // A single-dword request must carry a zero last byte enable.
        dw1     = {requester_id, tag, single ? 4'h0 : 4'hF, FIRST_BE};
        addr_lo = {addr[29:0], 2'b00};
        dword   = dw0;
        unique case (idx)
            2'd0: dword = dw0;
            2'd1: dword = dw1;
            2'd2: dword = addr64 ? addr[61:30] : addr_lo;
            2'd3: dword = addr_lo;
        endcase
    end

endmodule

// File: rtl/pcie_tlp_egress.sv
// Memory-request TLP egress engine: splits one request into MWr/MRd TLPs
// honouring payload/read limits and 4 KB boundaries, with full backpressure.
module pcie_tlp_egress
    import pcie_tlp_egress_pkg::*;
#(
    parameter int unsigned MAX_PAYLOAD_DW = 32,
    parameter int unsigned MAX_READ_DW    = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_enable,
    output logic        o_finished,
    input  logic        i_write,
    input  logic [13:0] i_flags,
    input  logic [63:0] i_address,
    input  logic [15:0] i_requester_id,
    input  logic [7:0]  i_tag,
    input  logic [23:0] i_length,
    input  logic        i_axi_egress_ready,
    output logic [31:0] o_axi_egress_data,
    output logic [3:0]  o_axi_egress_keep,
    output logic        o_axi_egress_last,
    output logic        o_axi_egress_valid,
    input  logic        i_fifo_rdy,
    output logic        o_fifo_act,
    input  logic [23:0] i_fifo_size,
    input  logic [31:0] i_fifo_data,
    output logic        o_fifo_stb
);

    state_e      state;
    logic        write;
    logic [61:0] addr;
    logic [23:0] remaining;
    logic [7:0]  tag;
    logic [15:0] req_id;
    logic [13:0] flags;
    logic [23:0] chunk;
    logic        addr64;
    logic [1:0]  hdr_idx;
    logic [23:0] beat;
    logic        valid;
    logic        last;
    logic        fifo_act;
    logic        finished;

    logic [23:0] max_dw;
    logic [23:0] boundary;
    logic [23:0] chunk_calc;
    logic [23:0] req_len;
    logic [1:0]  hdr_final;
    logic [31:0] hdr_dword;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^i_address[1:0];
    assign req_len          = i_write ? i_fifo_size : i_length;
    assign hdr_final        = addr64 ? 2'd3 : 2'd2;

    always_comb begin
        max_dw     = write ? 24'(MAX_PAYLOAD_DW) : 24'(MAX_READ_DW);
        boundary   = 24'd1024 - {14'd0, addr[9:0]};
        chunk_calc = remaining;
        if (max_dw < chunk_calc) chunk_calc = max_dw;
        if (boundary < chunk_calc) chunk_calc = boundary;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            write     <= 1'b0;
            addr      <= '0;
            remaining <= '0;
            tag       <= '0;
            req_id    <= '0;
            flags     <= '0;
            chunk     <= '0;
            addr64    <= 1'b0;
            hdr_idx   <= '0;
            beat      <= '0;
            valid     <= 1'b0;
            last      <= 1'b0;
            fifo_act  <= 1'b0;
            finished  <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (i_enable) begin
                        write     <= i_write;
                        addr      <= i_address[63:2];
                        remaining <= req_len;
                        tag       <= i_tag;
                        req_id    <= i_requester_id;
                        flags     <= i_flags;
                        if (req_len == 24'd0) begin
                            finished <= 1'b1;
                            state    <= StFinished;
                        end else begin
                            state <= i_write ? StWaitForFifo : StCalc;
                        end
                    end
                end
                StWaitForFifo: begin
                    if (i_fifo_rdy && !fifo_act) begin
                        fifo_act <= 1'b1;
                        state    <= StCalc;
                    end
                end
                StCalc: begin
                    chunk   <= chunk_calc;
                    addr64  <= |addr[61:30];
                    hdr_idx <= '0;
                    beat    <= '0;
                    valid   <= 1'b1;
                    last    <= 1'b0;
                    state   <= StSendHdr;
                end
                StSendHdr: begin
                    if (i_axi_egress_ready) begin
                        if (hdr_idx == hdr_final) begin
                            if (write) begin
                                last  <= (chunk == 24'd1);
                                state <= StSendData;
                            end else begin
                                valid <= 1'b0;
                                last  <= 1'b0;
                                state <= StNext;
                            end
                        end else begin
                            hdr_idx <= hdr_idx + 2'd1;
                            // Reads end the TLP on the final header dword.
                            last    <= !write && (hdr_idx + 2'd1 == hdr_final);
                        end
                    end
                end
                StSendData: begin
                    if (i_axi_egress_ready) begin
                        if (last) begin
                            valid <= 1'b0;
                            last  <= 1'b0;
                            state <= StNext;
                        end else begin
                            beat <= beat + 24'd1;
                            last <= (beat + 24'd2 == chunk);
                        end
                    end
                end
                StNext: begin
                    addr      <= addr + 62'(chunk);
                    remaining <= remaining - chunk;
                    if (!write) tag <= tag + 8'd1;
                    if (remaining == chunk) begin
                        fifo_act <= 1'b0;
                        finished <= 1'b1;
                        state    <= StFinished;
                    end else begin
                        state <= StCalc;
                    end
                end
                StFinished: begin
                    if (!i_enable) begin
                        finished <= 1'b0;
                        state    <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    pcie_tlp_hdr_gen u_hdr_gen (
        .write        (write),
        .addr64       (addr64),
        .addr         (addr),
        .length       (chunk[9:0]),
        .single       (chunk == 24'd1),
        .flags        (flags),
        .requester_id (req_id),
        .tag          (tag),
        .idx          (hdr_idx),
        .dword        (hdr_dword)
    );

    assign o_axi_egress_data  = (state == StSendData) ? i_fifo_data : hdr_dword;
    assign o_axi_egress_keep  = 4'hF;
    assign o_axi_egress_last  = last;
    assign o_axi_egress_valid = valid;
    assign o_fifo_act         = fifo_act;
    assign o_finished         = finished;
    assign o_fifo_stb         = (state == StSendData) && valid && i_axi_egress_ready;

endmodule

// File: tb/tb_pcie_tlp_egress.sv
// Directed bench for pcie_tlp_egress: header vectors, splitting, boundaries,
// backpressure and mid-TLP reset, against hand-computed beats.
module tb_pcie_tlp_egress;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_enable = 1'b0;
    logic        i_write = 1'b0;
    logic [13:0] i_flags = '0;
    logic [63:0] i_address = '0;
    logic [15:0] i_requester_id = 16'h0100;
    logic [7:0]  i_tag = '0;
    logic [23:0] i_length = '0;
    logic        i_axi_egress_ready = 1'b0;
    logic        i_fifo_rdy = 1'b0;
    logic [23:0] i_fifo_size = '0;
    logic [31:0] i_fifo_data;
    logic        o_finished;
    logic [31:0] o_axi_egress_data;
    logic [3:0]  o_axi_egress_keep;
    logic        o_axi_egress_last;
    logic        o_axi_egress_valid;
    logic        o_fifo_act;
    logic        o_fifo_stb;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] bdata[$];
    bit          blast[$];
    int          bcyc[$];
    int          tlp_first[$];
    int          n_stb, stall_err, first_valid, start_ptr;
    bit          timed_out, fin_cleared, act_seen;
    int unsigned fifo_ptr = 0;

    always #5 clk = ~clk;

    // First-word-fall-through FIFO model: each strobe pops one word.
    always @(posedge clk) if (o_fifo_stb) fifo_ptr <= fifo_ptr + 1;
    assign i_fifo_data = 32'hD000_0000 + fifo_ptr;

    pcie_tlp_egress #(
        .MAX_PAYLOAD_DW (32),
        .MAX_READ_DW    (32)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .i_enable           (i_enable),
        .o_finished         (o_finished),
        .i_write            (i_write),
        .i_flags            (i_flags),
        .i_address          (i_address),
        .i_requester_id     (i_requester_id),
        .i_tag              (i_tag),
        .i_length           (i_length),
        .i_axi_egress_ready (i_axi_egress_ready),
        .o_axi_egress_data  (o_axi_egress_data),
        .o_axi_egress_keep  (o_axi_egress_keep),
        .o_axi_egress_last  (o_axi_egress_last),
        .o_axi_egress_valid (o_axi_egress_valid),
        .i_fifo_rdy         (i_fifo_rdy),
        .o_fifo_act         (o_fifo_act),
        .i_fifo_size        (i_fifo_size),
        .i_fifo_data        (i_fifo_data),
        .o_fifo_stb         (o_fifo_stb)
    );

    // Drives one request to completion and records every accepted beat.
    task automatic run_req(input bit wr, input logic [63:0] a, input int len,
                           input logic [7:0] tg, input bit toggle);
        int          cyc;
        logic [31:0] pd;
        bit          pl, pstall, prev_last;
        bdata.delete(); blast.delete(); bcyc.delete(); tlp_first.delete();
        n_stb = 0; stall_err = 0; first_valid = -1; timed_out = 0; act_seen = 0;
        cyc = 0; pstall = 0; prev_last = 1; pd = '0; pl = 0;
        @(negedge clk);
        i_write = wr; i_address = a; i_tag = tg;
        i_fifo_size = wr ? 24'(len) : 24'd0;
        i_length = wr ? 24'd0 : 24'(len);
        i_enable = 1; i_fifo_rdy = 1; i_axi_egress_ready = 1;
        start_ptr = int'(fifo_ptr);
        while (!o_finished) begin
            @(negedge clk);
            cyc++;
            if (cyc > 3000) begin
                timed_out = 1;
                break;
            end
            i_axi_egress_ready = toggle ? cyc[0] : 1'b1;
            #1;
            if (pstall && (!o_axi_egress_valid || o_axi_egress_data !== pd ||
                           o_axi_egress_last !== pl)) stall_err++;
            if (o_fifo_act) act_seen = 1;
            if (o_fifo_stb) n_stb++;
            if (o_axi_egress_valid && first_valid < 0) first_valid = cyc;
            if (o_axi_egress_valid && i_axi_egress_ready) begin
                if (prev_last) tlp_first.push_back(bdata.size());
                bdata.push_back(o_axi_egress_data);
                blast.push_back(o_axi_egress_last);
                bcyc.push_back(cyc);
                prev_last = o_axi_egress_last;
            end
            pstall = o_axi_egress_valid && !i_axi_egress_ready;
            pd = o_axi_egress_data;
            pl = o_axi_egress_last;
        end
        i_enable = 0; i_axi_egress_ready = 1;
        @(negedge clk);
        #1;
        fin_cleared = !o_finished;
        i_fifo_rdy = 0;
        @(negedge clk);
    endtask

    // Counts data beats (after hdr_len header beats of each TLP) not matching the FIFO order.
    task automatic scan_data(input int hdr_len, output int ndata, output int nbad);
        int pos;
        ndata = 0; nbad = 0; pos = 0;
        for (int i = 0; i < bdata.size(); i++) begin
            if (pos >= hdr_len) begin
                if (bdata[i] !== 32'hD000_0000 + 32'(start_ptr + ndata)) nbad++;
                ndata++;
            end
            pos = blast[i] ? 0 : pos + 1;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        #1;
        n_tests++; if (o_axi_egress_valid !== 1'b0) begin n_fail++;
            $display("FAIL reset_valid: got %b want 0", o_axi_egress_valid); end
        n_tests++; if (o_axi_egress_last !== 1'b0) begin n_fail++;
            $display("FAIL reset_last: got %b want 0", o_axi_egress_last); end
        n_tests++; if (o_fifo_act !== 1'b0) begin n_fail++;
            $display("FAIL reset_fifo_act: got %b want 0", o_fifo_act); end
        n_tests++; if (o_finished !== 1'b0) begin n_fail++;
            $display("FAIL reset_finished: got %b want 0", o_finished); end
        n_tests++; if (o_axi_egress_keep !== 4'hF) begin n_fail++;
            $display("FAIL reset_keep: got %h want f", o_axi_egress_keep); end
        rst = 0;
        @(negedge clk);
    endtask

    task automatic test_single_write();
        logic [31:0] exp_d[4];
        bit          exp_l[4];
        exp_d = '{32'h4000_0001, 32'h0100_050F, 32'h0000_1000, 32'hD000_0000};
        exp_l = '{0, 0, 0, 1};
        run_req(1, 64'h1000, 1, 8'h05, 0);
        exp_d[3] = 32'hD000_0000 + 32'(start_ptr);
        n_tests++; if (timed_out) begin n_fail++; $display("FAIL single_timeout: got 1 want 0"); end
        n_tests++; if (bdata.size() != 4) begin n_fail++;
            $display("FAIL single_beats: got %0d want 4", bdata.size()); end
        for (int i = 0; i < 4 && i < bdata.size(); i++) begin
            n_tests++; if (bdata[i] !== exp_d[i] || blast[i] !== exp_l[i]) begin n_fail++;
                $display("FAIL single_beat%0d: got %h/%b want %h/%b",
                         i, bdata[i], blast[i], exp_d[i], exp_l[i]); end
        end
        n_tests++; if (n_stb != 1) begin n_fail++; $display("FAIL single_stb: got %0d want 1", n_stb); end
        n_tests++; if (first_valid != 3) begin n_fail++;
            $display("FAIL single_latency: got %0d want 3", first_valid); end
        n_tests++; if (!act_seen) begin n_fail++; $display("FAIL single_fifo_act: got 0 want 1"); end
        n_tests++; if (!fin_cleared) begin n_fail++; $display("FAIL single_fin_clear: got 1 want 0"); end
    endtask

    task automatic test_multi_write();
        logic [31:0] exp_dw0[3], exp_dw2[3];
        int          exp_nb[3];
        int          nd, nb, nxt;
        exp_dw0 = '{32'h4000_0020, 32'h4000_0020, 32'h4000_0006};
        exp_dw2 = '{32'h0000_2000, 32'h0000_2080, 32'h0000_2100};
        exp_nb  = '{35, 35, 9};
        run_req(1, 64'h2000, 70, 8'h07, 0);
        n_tests++; if (timed_out) begin n_fail++; $display("FAIL multi_timeout: got 1 want 0"); end
        n_tests++; if (tlp_first.size() != 3) begin n_fail++;
            $display("FAIL multi_tlps: got %0d want 3", tlp_first.size()); end
        for (int t = 0; t < 3 && t < tlp_first.size(); t++) begin
            nxt = (t + 1 < tlp_first.size()) ? tlp_first[t+1] : bdata.size();
            n_tests++; if (bdata[tlp_first[t]] !== exp_dw0[t]) begin n_fail++;
                $display("FAIL multi_dw0_%0d: got %h want %h", t, bdata[tlp_first[t]], exp_dw0[t]); end
            n_tests++; if (bdata[tlp_first[t]+1] !== 32'h0100_07FF) begin n_fail++;
                $display("FAIL multi_dw1_%0d: got %h want 010007ff", t, bdata[tlp_first[t]+1]); end
            n_tests++; if (bdata[tlp_first[t]+2] !== exp_dw2[t]) begin n_fail++;
                $display("FAIL multi_dw2_%0d: got %h want %h", t, bdata[tlp_first[t]+2], exp_dw2[t]); end
            n_tests++; if (nxt - tlp_first[t] != exp_nb[t]) begin n_fail++;
                $display("FAIL multi_len_%0d: got %0d want %0d", t, nxt - tlp_first[t], exp_nb[t]); end
            if (t > 0) begin
                n_tests++; if (bcyc[tlp_first[t]] - bcyc[tlp_first[t]-1] != 3) begin n_fail++;
                    $display("FAIL multi_gap_%0d: got %0d want 3",
                             t, bcyc[tlp_first[t]] - bcyc[tlp_first[t]-1]); end
            end
        end
        scan_data(3, nd, nb);
        n_tests++; if (n_stb != 70) begin n_fail++; $display("FAIL multi_stb: got %0d want 70", n_stb); end
        n_tests++; if (nd != 70 || nb != 0) begin n_fail++;
            $display("FAIL multi_data: got %0d beats %0d bad want 70 beats 0 bad", nd, nb); end
    endtask

    task automatic test_boundary();
        logic [31:0] exp_dw0[2], exp_dw2[2];
        int          nd, nb;
        exp_dw0 = '{32'h4000_0002, 32'h4000_0006};
        exp_dw2 = '{32'h0000_0FF8, 32'h0000_1000};
        run_req(1, 64'h0FF8, 8, 8'h09, 0);
        n_tests++; if (timed_out) begin n_fail++; $display("FAIL bound_timeout: got 1 want 0"); end
        n_tests++; if (tlp_first.size() != 2 || bdata.size() != 14) begin n_fail++;
            $display("FAIL bound_shape: got %0d tlps %0d beats want 2 tlps 14 beats",
                     tlp_first.size(), bdata.size()); end
        for (int t = 0; t < 2 && t < tlp_first.size(); t++) begin
            n_tests++; if (bdata[tlp_first[t]] !== exp_dw0[t] ||
                           bdata[tlp_first[t]+2] !== exp_dw2[t]) begin n_fail++;
                $display("FAIL bound_hdr_%0d: got %h/%h want %h/%h", t, bdata[tlp_first[t]],
                         bdata[tlp_first[t]+2], exp_dw0[t], exp_dw2[t]); end
        end
        scan_data(3, nd, nb);
        n_tests++; if (n_stb != 8 || nb != 0) begin n_fail++;
            $display("FAIL bound_data: got %0d stb %0d bad want 8 stb 0 bad", n_stb, nb); end
    endtask

    task automatic test_read_4dw();
        logic [31:0] exp_d[8];
        bit          exp_l[8];
        exp_d = '{32'h2000_0020, 32'h0100_10FF, 32'h0000_0001, 32'h0000_0000,
                  32'h2000_0008, 32'h0100_11FF, 32'h0000_0001, 32'h0000_0080};
        exp_l = '{0, 0, 0, 1, 0, 0, 0, 1};
        run_req(0, 64'h1_0000_0000, 40, 8'h10, 0);
        n_tests++; if (timed_out) begin n_fail++; $display("FAIL read_timeout: got 1 want 0"); end
        n_tests++; if (bdata.size() != 8) begin n_fail++;
            $display("FAIL read_beats: got %0d want 8", bdata.size()); end
        for (int i = 0; i < 8 && i < bdata.size(); i++) begin
            n_tests++; if (bdata[i] !== exp_d[i] || blast[i] !== exp_l[i]) begin n_fail++;
                $display("FAIL read_beat%0d: got %h/%b want %h/%b",
                         i, bdata[i], blast[i], exp_d[i], exp_l[i]); end
        end
        n_tests++; if (n_stb != 0 || act_seen) begin n_fail++;
            $display("FAIL read_fifo: got stb %0d act %b want 0 0", n_stb, act_seen); end
        n_tests++; if (first_valid != 2) begin n_fail++;
            $display("FAIL read_latency: got %0d want 2", first_valid); end
        if (bcyc.size() == 8) begin
            n_tests++; if (bcyc[4] - bcyc[3] != 3) begin n_fail++;
                $display("FAIL read_gap: got %0d want 3", bcyc[4] - bcyc[3]); end
        end
    endtask

    task automatic test_backpressure();
        int nd, nb, nl;
        run_req(1, 64'h3000, 16, 8'h33, 1);
        nl = 0;
        foreach (blast[i]) if (blast[i]) nl++;
        scan_data(3, nd, nb);
        n_tests++; if (timed_out) begin n_fail++; $display("FAIL bp_timeout: got 1 want 0"); end
        n_tests++; if (bdata.size() != 19 || nl != 1) begin n_fail++;
            $display("FAIL bp_shape: got %0d beats %0d lasts want 19 beats 1 last", bdata.size(), nl); end
        n_tests++; if (bdata.size() > 0 && bdata[0] !== 32'h4000_0010) begin n_fail++;
            $display("FAIL bp_dw0: got %h want 40000010", bdata[0]); end
        n_tests++; if (stall_err != 0) begin n_fail++;
            $display("FAIL bp_stable: got %0d unstable stalls want 0", stall_err); end
        n_tests++; if (n_stb != 16 || nd != 16 || nb != 0) begin n_fail++;
            $display("FAIL bp_data: got %0d stb %0d beats %0d bad want 16 16 0", n_stb, nd, nb); end
    endtask

    task automatic test_reset_mid();
        int cnt, cyc, nd, nb;
        @(negedge clk);
        i_write = 1; i_address = 64'h4000; i_fifo_size = 24'd16; i_tag = 8'h21;
        i_enable = 1; i_fifo_rdy = 1; i_axi_egress_ready = 1;
        cnt = 0; cyc = 0;
        while (cnt < 6 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            #1;
            if (o_fifo_stb) cnt++;
        end
        n_tests++; if (cnt < 6) begin n_fail++;
            $display("FAIL rstmid_reach: got %0d strobes want 6", cnt); end
        rst = 1;
        @(negedge clk);
        #1;
        n_tests++; if (o_axi_egress_valid !== 1'b0 || o_axi_egress_last !== 1'b0) begin n_fail++;
            $display("FAIL rstmid_valid_last: got %b/%b want 0/0", o_axi_egress_valid,
                     o_axi_egress_last); end
        n_tests++; if (o_fifo_act !== 1'b0 || o_finished !== 1'b0 || o_fifo_stb !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_ctrl: got act %b fin %b stb %b want 0 0 0",
                     o_fifo_act, o_finished, o_fifo_stb); end
        rst = 0; i_enable = 0; i_fifo_rdy = 0;
        @(negedge clk);
        run_req(1, 64'h5000, 4, 8'h22, 0);
        scan_data(3, nd, nb);
        n_tests++; if (timed_out || bdata.size() != 7) begin n_fail++;
            $display("FAIL rstmid_after_beats: got %0d want 7", bdata.size()); end
        n_tests++; if (bdata.size() == 7 && (bdata[0] !== 32'h4000_0004 ||
                       bdata[2] !== 32'h0000_5000)) begin n_fail++;
            $display("FAIL rstmid_after_hdr: got %h/%h want 40000004/00005000", bdata[0], bdata[2]); end
        n_tests++; if (n_stb != 4 || nb != 0) begin n_fail++;
            $display("FAIL rstmid_after_data: got %0d stb %0d bad want 4 0", n_stb, nb); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_multi_write();
        test_boundary();
        test_read_4dw();
        test_backpressure();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pcie_tlp_egress.md
# pcie_tlp_egress

Parametrised memory-request TLP egress engine. It sits between the Nysa PCIe controller and the PCIe core's 32-bit AXI-Stream transmit interface. A single enable-level request of arbitrary length is split into spec-compliant MWr/MRd TLPs. Splitting honours the max payload size, the max read request size and 4 KB boundaries, and uses 3DW or 4DW headers as the address requires. Every beat is subject to full ready/valid backpressure.

## Interface
- MAX_PAYLOAD_DW, 32, max MWr payload in dwords; power of two, 1..512.
- MAX_READ_DW, 128, max MRd request length in dwords; power of two, 1..512.
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- i_enable  in  1  request level; held high until o_finished.
- o_finished  out  1  request complete; held until i_enable low.
- i_write  in  1  1 = MWr from FIFO, 0 = MRd.
- i_flags  in  14  header dword0 bits [23:10] (TC/TD/EP/attr).
- i_address  in  64  start byte address; bits [1:0] ignored.
- i_requester_id  in  16  requester ID.
- i_tag  in  8  tag of first TLP.
- i_length  in  24  MRd total length in dwords.
- i_axi_egress_ready  in  1  core ready.
- o_axi_egress_data  out  32  beat data.
- o_axi_egress_keep  out  4  constant 4'hF.
- o_axi_egress_last  out  1  last beat of TLP.
- o_axi_egress_valid  out  1  beat valid.
- i_fifo_rdy  in  1  FIFO block available.
- o_fifo_act  out  1  FIFO block claimed.
- i_fifo_size  in  24  FIFO block size in dwords; this is the MWr total length.
- i_fifo_data  in  32  first-word-fall-through FIFO data.
- o_fifo_stb  out  1  pop FIFO word.

## Operation
- Request capture: on i_enable in IDLE, latch address (dword address, 62 bits), remaining = i_write ? i_fifo_size : i_length, and tag.
  - Zero remaining: go to FINISHED; no TLPs are emitted and the FIFO is not claimed.
- States: IDLE, WAIT_FOR_FIFO, CALC, SEND_HDR, SEND_DATA, NEXT, FINISHED.
- IDLE: on i_enable, go to WAIT_FOR_FIFO (write) or CALC (read).
- WAIT_FOR_FIFO: when i_fifo_rdy && !o_fifo_act, set o_fifo_act and go to CALC.
- CALC: register chunk = min(remaining, MAX, 1024 − addr[11:2]), where MAX = MAX_PAYLOAD_DW for writes and MAX_READ_DW for reads. Register addr64 = |addr[63:32].
- Header construction:
  - dword0 = {1'b0, i_write, addr64, 5'b00000, i_flags, chunk[9:0]}.
  - dword1 = {requester_id, tag, last_be, 4'hF}, where last_be = (chunk == 1) ? 4'h0 : 4'hF.
  - 3DW header: dword2 = {addr[31:2], 2'b00}.
  - 4DW header: dword2 = addr[63:32], dword3 = {addr[31:2], 2'b00}.
- SEND_HDR: the header index advances on each accepted beat. After the last header beat, go to SEND_DATA (write) or NEXT (read). For reads, last is asserted on the final header beat.
- SEND_DATA:
  - o_axi_egress_data = i_fifo_data.
  - o_fifo_stb = valid && ready; it is combinational, one pulse per accepted beat.
  - Last is asserted on beat number chunk.
  - After the last beat is accepted, go to NEXT.
- NEXT: addr += chunk; remaining −= chunk; tag += 1 (reads only, wraps at 8 bits). If remaining == 0, go to FINISHED, otherwise go to CALC.
- FINISHED: valid = 0, o_fifo_act = 0, o_finished = 1. When i_enable is low, clear o_finished and go to IDLE.
- i_enable dropping mid-request is ignored; the request completes.
- Address wraps modulo 2^64.

## Timing
- Reset values: o_finished 0, o_axi_egress_valid 0, o_axi_egress_last 0, o_fifo_act 0, o_fifo_stb 0, o_axi_egress_data = header dword0 of a zero-length request (don't-care while valid is low). State goes to IDLE.
- Reset mid-TLP: all outputs are at their reset values on the next cycle. The partial TLP is abandoned; the core owns recovery.
- Handshake: a beat transfers on valid && ready. While ready is low, data and last are held stable. Valid is never withdrawn until the beat is accepted.
- Request latency:
  - Write: i_enable high → WAIT_FOR_FIFO next cycle; i_fifo_rdy → o_fifo_act next cycle; CALC 1 cycle; valid on the following cycle with header dword0.
  - Read: i_enable → CALC → valid 2 cycles after i_enable.
- Inter-TLP gap: exactly 2 cycles with valid low (NEXT, CALC).
- Throughput: 1 beat/cycle while ready is high.

## Structure
- Shared pcie_defines additions: FMT/TYPE constants for MWr/MRd, header bit ranges (FMT, TYPE, FLAGS, LENGTH, BE), and state encodings.
- One sub-module, pcie_tlp_hdr_gen: combinational header dword mux from the latched address, chunk, tag, requester ID and flags, selected by header index.

## Test plan
- MWr of 1 DW to 0x1000 with rid 0x0100, tag 0x05:
  - Beats 0x40000001, 0x0100050F, 0x00001000, then data.
  - last on the data beat; exactly one o_fifo_stb.
- MWr of 70 DW at 0x2000 with MAX_PAYLOAD_DW = 32:
  - Three TLPs of lengths 32, 32, 6 at addresses 0x2000, 0x2080, 0x2100.
  - 70 strobes; 2-cycle gaps between TLPs.
- MWr of 8 DW at 0x0FF8: TLP of length 2 at 0x0FF8, then length 6 at 0x1000.
- MRd of 40 DW at 0x1_0000_0000 with MAX_READ_DW = 32, tag 0x10:
  - 4DW headers with dword0 0x20000020 (tag 0x10), then 0x20000008 (tag 0x11).
  - last on dword3 of each TLP; no o_fifo_stb.
- MWr of 16 DW with ready toggling every cycle: no dropped or duplicated beats, data stable while stalled, 16 strobes.
- rst asserted mid-SEND_DATA: valid, last, o_fifo_act and o_finished are 0 on the next cycle; a following request completes normally.
